jpeg_blk_seq: RTL and testbench

- Cycle-exact sequencer for one 8x8 JPEG block through the accelerator datapath.
- Datapath order: input blockram, 8-point DCT row pass, transpose memory, DCT column pass, quantizer, output blockram.
- Replaces the ad-hoc divided-clock control counters with one counter-driven FSM on the bus clock.
- Started by the DMA engine or a control-register write. Reports busy/done back to the DMA engine and the status register.

---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/jpeg_col_wr.sv | 28 ++
 rtl/jpeg_blk_seq.sv | 143 ++++++++++++++
 tb/tb_jpeg_blk_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG block sequencer.
// States, strobe bundle and block geometry.
package jpeg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic       in_rd;
    logic       dct_en;
    logic       mux1;
    logic       t_wr;
    logic       t_rd;
    logic [1:0] mux2_sel;
    logic       out_we;
  } ctrl_t;

  localparam int BLK_WORDS = 16;
  localparam int OUT_WORDS = 32;

endpackage

// File: rtl/jpeg_col_wr.sv
// Column-pass write sub-counter for the output blockram.
// Index is 4k+j; the quantizer pair select is its low two bits.
module jpeg_col_wr
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       clr,
  output logic       we,
  output logic [4:0] idx
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      we  <= 1'b0;
      idx <= '0;
    end else if (go) begin
      we  <= 1'b1;
      idx <= '0;
    end else if (we) begin
      // idx wraps to 0 after the last word, matching the idle value
      we  <= (idx != 5'(OUT_WORDS - 1));
      idx <= idx + 5'd1;
    end
  end

endmodule

// File: rtl/jpeg_blk_seq.sv
// Counter-driven sequencer for one 8x8 block through the
// row DCT, transpose, column DCT and quantizer datapath.
module jpeg_blk_seq
  import jpeg_pkg::*;
#(
  parameter int DCT_LAT = 4,
  parameter int CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        in_rd_o,
  output logic [3:0]  in_addr_o,
  output logic        dct_en_o,
  output logic        mux1_o,
  output logic        t_wr_o,
  output logic        t_rd_o,
  output logic [1:0]  mux2_sel_o,
  output logic [5:0]  rec_idx_o,
  output logic        out_we_o,
  output logic [4:0]  out_addr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] blk_cnt_o
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST = cnt_t'(49 + 2 * DCT_LAT);
  localparam cnt_t C0   = cnt_t'(17 + DCT_LAT);
  localparam cnt_t LAT  = cnt_t'(DCT_LAT);
  localparam cnt_t WR0  = cnt_t'(18 + 2 * DCT_LAT);
  localparam cnt_t TW0  = cnt_t'(2 + DCT_LAT);
  localparam cnt_t TW1  = cnt_t'(16 + DCT_LAT);
  localparam cnt_t NBW  = cnt_t'(BLK_WORDS);
  localparam cnt_t K2   = cnt_t'(2);
  localparam cnt_t K16  = cnt_t'(16);
  localparam cnt_t K28  = cnt_t'(28);
  localparam cnt_t K29  = cnt_t'(29);

  seq_state_t  state, nstate;
  cnt_t        c, nc, dc;
  ctrl_t       strb, nstrb, ctrl;
  logic [3:0]  in_addr, naddr;
  logic        busy, done;
  logic [15:0] cnt;
  logic        go, clr, we;
  logic [4:0]  idx;

  always_comb begin
    nstate = state;
    nc     = c;
    case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          nstate = RUN;
          nc     = '0;
        end
      end
      RUN: begin
        if (abort_i)        nstate = IDLE;
        else if (c >= LAST) nstate = DONE;
        else                nc     = c + cnt_t'(1);
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Strobes are decoded from the next count and registered
  always_comb begin
    nstrb = '0;
    naddr = '0;
    dc    = nc - C0;
    go    = 1'b0;
    clr   = (nstate != RUN);
    if (nstate == RUN) begin
      nstrb.in_rd  = (nc < NBW);
      naddr        = (nc < NBW) ? nc[3:0] : 4'd0;
      nstrb.mux1   = (nc >= C0);
      nstrb.t_wr   = (nc >= TW0) && (nc <= TW1) &&
                     (nc[0] == LAT[0]);
      nstrb.t_rd   = (nc >= C0) && (dc <= K28) &&
                     (dc[1:0] == 2'd0);
      nstrb.dct_en = ((nc >= K2) && (nc <= K16) && !nc[0]) ||
                     ((nc > C0) && (dc <= K29) &&
                      (dc[1:0] == 2'd1));
      go           = (nc == WR0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      c       <= '0;
      strb    <= '0;
      in_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= nstate;
      c       <= nc;
      strb    <= nstrb;
      in_addr <= naddr;
      busy    <= (nstate != IDLE);
      done    <= (nstate == DONE);
      if (state == RUN && nstate == DONE)
        cnt <= cnt + 16'd1;
    end
  end

  jpeg_col_wr u_col_wr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .go    (go),
    .clr   (clr),
    .we    (we),
    .idx   (idx)
  );

  always_comb begin
    ctrl          = strb;
    ctrl.mux2_sel = idx[1:0];
    ctrl.out_we   = we;
  end

  assign in_rd_o    = ctrl.in_rd;
  assign in_addr_o  = in_addr;
  assign dct_en_o   = ctrl.dct_en;
  assign mux1_o     = ctrl.mux1;
  assign t_wr_o     = ctrl.t_wr;
  assign t_rd_o     = ctrl.t_rd;
  assign mux2_sel_o = ctrl.mux2_sel;
  assign rec_idx_o  = {idx, 1'b0};
  assign out_we_o   = ctrl.out_we;
  assign out_addr_o = idx;
  assign busy_o     = busy;
  assign done_o     = done;
  assign blk_cnt_o  = cnt;

endmodule

// File: tb/tb_jpeg_blk_seq.sv
// Scoreboard bench for jpeg_blk_seq: L=4 main instance plus
// L=1 and L=8 instances for the latency sweep.
module tb_jpeg_blk_seq;

  typedef struct {
    int cyc;
    int a;
    int b;
    int d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start_sw = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rd, dct, mux1, twr, trd, we, busy, done;
  logic [3:0]  addr;
  logic [1:0]  sel;
  logic [5:0]  rec;
  logic [4:0]  oaddr;
  logic [15:0] bcnt;

  logic        sw_rd[2], sw_dct[2], sw_mux1[2], sw_twr[2];
  logic        sw_trd[2], sw_we[2], sw_busy[2], sw_done[2];
  logic [3:0]  sw_addr[2];
  logic [1:0]  sw_sel[2];
  logic [5:0]  sw_rec[2];
  logic [4:0]  sw_oaddr[2];
  logic [15:0] sw_bcnt[2];

  jpeg_blk_seq #(.DCT_LAT(4), .CNT_W(7)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .abort_i(abort), .in_rd_o(rd), .in_addr_o(addr),
    .dct_en_o(dct), .mux1_o(mux1), .t_wr_o(twr),
    .t_rd_o(trd), .mux2_sel_o(sel), .rec_idx_o(rec),
    .out_we_o(we), .out_addr_o(oaddr), .busy_o(busy),
    .done_o(done), .blk_cnt_o(bcnt)
  );

  jpeg_blk_seq #(.DCT_LAT(1), .CNT_W(7)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_sw),
    .abort_i(1'b0), .in_rd_o(sw_rd[0]),
    .in_addr_o(sw_addr[0]), .dct_en_o(sw_dct[0]),
    .mux1_o(sw_mux1[0]), .t_wr_o(sw_twr[0]),
    .t_rd_o(sw_trd[0]), .mux2_sel_o(sw_sel[0]),
    .rec_idx_o(sw_rec[0]), .out_we_o(sw_we[0]),
    .out_addr_o(sw_oaddr[0]), .busy_o(sw_busy[0]),
    .done_o(sw_done[0]), .blk_cnt_o(sw_bcnt[0])
  );

  jpeg_blk_seq #(.DCT_LAT(8), .CNT_W(7)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_sw),
    .abort_i(1'b0), .in_rd_o(sw_rd[1]),
    .in_addr_o(sw_addr[1]), .dct_en_o(sw_dct[1]),
    .mux1_o(sw_mux1[1]), .t_wr_o(sw_twr[1]),
    .t_rd_o(sw_trd[1]), .mux2_sel_o(sw_sel[1]),
    .rec_idx_o(sw_rec[1]), .out_we_o(sw_we[1]),
    .out_addr_o(sw_oaddr[1]), .busy_o(sw_busy[1]),
    .done_o(sw_done[1]), .blk_cnt_o(sw_bcnt[1])
  );

  int errors = 0;
  int checks = 0;
  ev_t q[6][$];
  string nm[6] = '{"rd", "dct", "t_wr", "t_rd", "we", "done"};

  int n_rd[2], n_dct[2], n_col[2], n_tw[2], n_tr[2];
  int n_we[2], last_we[2], d_at[2];
  int exp_last[2] = '{51, 65};
  int exp_done[2] = '{52, 66};

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ty, input int cy, input int a,
                      input int b, input int d);
    ev_t e;
    e.cyc = cy;
    e.a = a;
    e.b = b;
    e.d = d;
    q[ty].push_back(e);
  endtask

  // Expected L=4 schedule, events up to RUN cycle cmax
  task automatic push_block(input int t0, input int cmax,
                            input int cnt, input bit dn);
    for (int c = 0; c < 16; c++)
      if (c <= cmax) push(0, t0 + c, c, 0, 0);
    for (int r = 0; r < 8; r++)
      if (2 * r + 2 <= cmax) push(1, t0 + 2 * r + 2, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      if (22 + 4 * k <= cmax) push(1, t0 + 22 + 4 * k, 1, 0, 0);
    for (int r = 0; r < 8; r++)
      if (6 + 2 * r <= cmax) push(2, t0 + 6 + 2 * r, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      if (21 + 4 * k <= cmax) push(3, t0 + 21 + 4 * k, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++)
        if (26 + 4 * k + j <= cmax)
          push(4, t0 + 26 + 4 * k + j, 4 * k + j, 8 * k + 2 * j, j);
    if (dn) push(5, t0 + 58, cnt, 0, 0);
  endtask

  task automatic chk_q(input int ty, input bit act, input int a,
                       input int b, input int d);
    ev_t e;
    while (q[ty].size() > 0 && q[ty][0].cyc < cyc) begin
      e = q[ty].pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing: expected at cyc %0d, now %0d",
               nm[ty], e.cyc, cyc);
    end
    if (act) begin
      checks++;
      if (q[ty].size() > 0 && q[ty][0].cyc == cyc) begin
        e = q[ty].pop_front();
        if (e.a != a || e.b != b || e.d != d) begin
          errors++;
          $display("FAIL %s data cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                   nm[ty], cyc, a, b, d, e.a, e.b, e.d);
        end
      end else begin
        errors++;
        $display("FAIL %s spurious strobe at cyc %0d", nm[ty], cyc);
      end
    end
  endtask

  task automatic monitor();
    chk_q(0, rd, int'(addr), 0, 0);
    chk_q(1, dct, int'(mux1), 0, 0);
    chk_q(2, twr, 0, 0, 0);
    chk_q(3, trd, 0, 0, 0);
    chk_q(4, we, int'(oaddr), int'(rec), int'(sel));
    chk_q(5, done, int'(bcnt), 0, 0);
    if (!we) chk("idle_wr_fields", int'({oaddr, sel, rec}), 0);
    for (int i = 0; i < 2; i++) begin
      if (sw_rd[i]) begin
        chk("sw_in_addr", int'(sw_addr[i]), n_rd[i]);
        n_rd[i]++;
      end
      if (sw_dct[i]) begin
        n_dct[i]++;
        if (sw_mux1[i]) n_col[i]++;
      end
      if (sw_twr[i]) n_tw[i]++;
      if (sw_trd[i]) n_tr[i]++;
      if (sw_we[i]) begin
        chk("sw_out_addr", int'(sw_oaddr[i]), n_we[i]);
        chk("sw_sel", int'(sw_sel[i]), n_we[i] % 4);
        chk("sw_rec", int'(sw_rec[i]), 2 * n_we[i]);
        n_we[i]++;
        last_we[i] = cyc;
      end
      if (sw_done[i]) d_at[i] = cyc;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic stimulus();
    int t0;
    int ts;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(bcnt), 0);
    chk("rst_strobes",
        int'({rd, dct, mux1, twr, trd, we, addr, sel, rec, oaddr}), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    t0 = cyc + 1;
    push_block(t0, 57, 1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 5);
    chk("busy_run", int'(busy), 1);
    wait_cyc(t0 + 58);
    chk("busy_done", int'(busy), 1);
    chk("cnt_done", int'(bcnt), 1);
    wait_cyc(t0 + 59);
    chk("busy_idle", int'(busy), 0);
    @(negedge clk);

    t0 = cyc + 1;
    push_block(t0, 57, 2, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 60);
    chk("cnt_ignored_start", int'(bcnt), 2);

    t0 = cyc + 1;
    push_block(t0, 30, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 30);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cnt", int'(bcnt), 2);
    t0 = cyc + 1;
    push_block(t0, 57, 3, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 60);
    chk("restart_cnt", int'(bcnt), 3);

    t0 = cyc + 1;
    for (int b = 0; b < 3; b++)
      push_block(t0 + 60 * b, 57, 4 + b, 1'b1);
    start = 1'b1;
    wait_cyc(t0 + 130);
    start = 1'b0;
    wait_cyc(t0 + 185);
    chk("b2b_cnt", int'(bcnt), 6);
    chk("b2b_busy", int'(busy), 0);

    force u4.cnt = 16'hFFFF;
    @(negedge clk);
    release u4.cnt;
    chk("preset_cnt", int'(bcnt), 16'hFFFF);
    t0 = cyc + 1;
    push_block(t0, 57, 0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 60);
    chk("wrap_cnt", int'(bcnt), 0);

    ts = cyc + 1;
    start_sw = 1'b1;
    @(negedge clk);
    start_sw = 1'b0;
    wait_cyc(ts + 80);
    for (int i = 0; i < 2; i++) begin
      chk("sw_rd_count", n_rd[i], 16);
      chk("sw_dct_count", n_dct[i], 16);
      chk("sw_col_dct_count", n_col[i], 8);
      chk("sw_t_wr_count", n_tw[i], 8);
      chk("sw_t_rd_count", n_tr[i], 8);
      chk("sw_we_count", n_we[i], 32);
      chk("sw_last_write_c", last_we[i] - ts, exp_last[i]);
      chk("sw_done_c", d_at[i] - ts, exp_done[i]);
      chk("sw_blk_cnt", int'(sw_bcnt[i]), 1);
      chk("sw_busy_end", int'(sw_busy[i]), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
      stimulus();
    join_any
    disable fork;
    for (int ty = 0; ty < 6; ty++)
      chk({"leftover_", nm[ty]}, q[ty].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
